// File: rtl/coax_pkg.sv
// coax_pkg: shared definitions for the 3270 coax receive path.
//   - coax_state_t : receive sequencer states
//   - COAX_WORD_W  : width of one received coax word
//   - COAX_ENTRY_W : width of one frame FIFO entry, {last, word}
//   - packEntry    : builds a FIFO entry from a word and its last flag
package coax_pkg;

  localparam int COAX_WORD_W  = 12;
  localparam int COAX_ENTRY_W = COAX_WORD_W + 1;

  typedef enum logic [1:0] {
    HOLD  = 2'd0,
    TURN  = 2'd1,
    IDLE  = 2'd2,
    FRAME = 2'd3
  } coax_state_t;

  function automatic logic [COAX_ENTRY_W-1:0] packEntry(
    input logic                   last,
    input logic [COAX_WORD_W-1:0] word
  );
    return {last, word};
  endfunction

endpackage

// File: rtl/coax_sync_fifo.sv
// coax_sync_fifo: single-clock show-ahead FIFO.
//   clk, reset (sync, active-low)
//   push, pushData  : write side; a push to a full FIFO is ignored unless a
//                     pop happens in the same cycle, in which case both occur
//   pop             : consume the head entry (ignored when empty)
//   popData         : head entry, valid whenever empty==0; reads 0 when empty
//   full, empty     : status flags
module coax_sync_fifo #(
  parameter int WIDTH = 13,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] pushData,
  input  logic             pop,
  output logic [WIDTH-1:0] popData,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wrPtr;
  logic [PW-1:0]    rdPtr;
  logic             doPush;
  logic             doPop;

  // Pointers carry one extra wrap bit: equal addresses with differing wrap
  // bits means full, identical pointers means empty.
  assign empty = (wrPtr == rdPtr);
  assign full  = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);

  assign doPop  = pop && !empty;
  // A pop frees the slot in the same cycle, so a push onto a full FIFO is
  // accepted when it coincides with a pop.
  assign doPush = push && (!full || doPop);

  always_ff @(posedge clk) begin
    if (!reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + PW'(1);
      if (doPop)  rdPtr <= rdPtr + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr[AW-1:0]] <= pushData;
  end

  // Gated so stale or uninitialised storage never shows on the output.
  assign popData = empty ? '0 : mem[rdPtr[AW-1:0]];

endmodule

// File: rtl/coax_rx_ctrl.sv
// coax_rx_ctrl: receive-side sequencer for the 3270 coax receiver.
// Keeps the receiver in reset while the local transmitter owns the line and
// for a turnaround window after it releases it, groups received words into
// frames by inter-word silence, and buffers {last, word} entries in a FIFO.
//
// Ports:
//   clk            system clock
//   reset          synchronous, active-low
//   txBusy         transmitter is driving the line
//   rxReset        registered active-high reset to the receiver
//   rxWord         received word, qualified by wordAvailable (1-cycle strobe)
//   outWord        head-of-FIFO word
//   outLast        head word closes its frame
//   outValid       FIFO not empty
//   outReady       host accepts the head word (pop on outValid && outReady)
//   frameActive    registered: controller is in FRAME
//   overflow       sticky: a word was dropped on a full FIFO
//   overflowClear  clears overflow (a simultaneous drop wins)
//   dbgState       current controller state
//
// Handshake: a word transfers on every clk edge where outValid && outReady
// are both 1; outWord/outLast are stable while outValid=1 and outReady=0.
module coax_rx_ctrl
  import coax_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int EOF_TIMEOUT = 1024,
  parameter int TURNAROUND  = 256
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   txBusy,
  output logic                   rxReset,
  input  logic [COAX_WORD_W-1:0] rxWord,
  input  logic                   wordAvailable,
  output logic [COAX_WORD_W-1:0] outWord,
  output logic                   outLast,
  output logic                   outValid,
  input  logic                   outReady,
  output logic                   frameActive,
  output logic                   overflow,
  input  logic                   overflowClear,
  output coax_state_t            dbgState
);

  localparam int CNT_MAX = (EOF_TIMEOUT > TURNAROUND) ? EOF_TIMEOUT : TURNAROUND;
  localparam int CNT_W   = $clog2(CNT_MAX);

  localparam logic [CNT_W-1:0] TURN_LAST = CNT_W'(TURNAROUND - 1);
  localparam logic [CNT_W-1:0] EOF_LAST  = CNT_W'(EOF_TIMEOUT - 1);

  coax_state_t state;
  coax_state_t stateNext;

  logic [CNT_W-1:0]       turnCnt;
  logic [CNT_W-1:0]       turnCntNext;
  logic [CNT_W-1:0]       silCnt;
  logic [CNT_W-1:0]       silCntNext;

  logic [COAX_WORD_W-1:0] stagedWord;
  logic                   stagedValid;
  logic                   stageLoad;
  logic                   pushReq;
  logic                   pushLast;

  logic [COAX_ENTRY_W-1:0] fifoHead;
  logic                    fifoFull;
  logic                    fifoEmpty;
  logic                    popReq;
  logic                    fifoPush;

  // ---------------------------------------------------------------------
  // State and counter registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= HOLD;
      turnCnt <= '0;
      silCnt  <= '0;
    end else begin
      state   <= stateNext;
      turnCnt <= turnCntNext;
      silCnt  <= silCntNext;
    end
  end

  // ---------------------------------------------------------------------
  // Next-state logic. txBusy has priority everywhere: the transmitter
  // owning the line overrides any word strobe seen in the same cycle.
  // Counters saturate at all-ones so they never wrap back into range.
  // ---------------------------------------------------------------------
  always_comb begin
    stateNext   = state;
    turnCntNext = turnCnt;
    silCntNext  = silCnt;
    stageLoad   = 1'b0;
    pushReq     = 1'b0;
    pushLast    = 1'b0;

    unique case (state)
      HOLD: begin
        if (!txBusy) begin
          stateNext   = TURN;
          turnCntNext = '0;
        end
      end

      TURN: begin
        if (txBusy) begin
          stateNext = HOLD;
        end else if (turnCnt == TURN_LAST) begin
          stateNext = IDLE;
        end else if (turnCnt != '1) begin
          turnCntNext = turnCnt + CNT_W'(1);
        end
      end

      IDLE: begin
        if (txBusy) begin
          stateNext = HOLD;
        end else if (wordAvailable) begin
          stageLoad  = 1'b1;
          silCntNext = '0;
          stateNext  = FRAME;
        end
      end

      FRAME: begin
        if (txBusy) begin
          // Close the frame on the word already staged; a word strobed in
          // this cycle arrived while the line was being taken and is lost.
          pushReq   = stagedValid;
          pushLast  = 1'b1;
          stateNext = HOLD;
        end else if (wordAvailable) begin
          pushReq    = stagedValid;
          stageLoad  = 1'b1;
          silCntNext = '0;
        end else if (silCnt == EOF_LAST) begin
          pushReq   = stagedValid;
          pushLast  = 1'b1;
          stateNext = IDLE;
        end else if (silCnt != '1) begin
          silCntNext = silCnt + CNT_W'(1);
        end
      end

      default: stateNext = HOLD;
    endcase
  end

  // ---------------------------------------------------------------------
  // Staging register: holds the newest word until we know whether it is
  // the last of its frame (next strobe, silence timeout or txBusy).
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      stagedWord  <= '0;
      stagedValid <= 1'b0;
    end else if (stageLoad) begin
      stagedWord  <= rxWord;
      stagedValid <= 1'b1;
    end else if (pushReq) begin
      stagedValid <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------
  // Registered outputs derived from the state
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      rxReset     <= 1'b1;
      frameActive <= 1'b0;
    end else begin
      rxReset     <= (state == HOLD) || (state == TURN);
      frameActive <= (state == FRAME);
    end
  end

  // ---------------------------------------------------------------------
  // Overflow: a push is dropped only when the FIFO is full and no pop
  // frees a slot in the same cycle. Set takes priority over clear.
  // ---------------------------------------------------------------------
  assign popReq   = outValid && outReady;
  assign fifoPush = pushReq;

  always_ff @(posedge clk) begin
    if (!reset) begin
      overflow <= 1'b0;
    end else if (fifoPush && fifoFull && !popReq) begin
      overflow <= 1'b1;
    end else if (overflowClear) begin
      overflow <= 1'b0;
    end
  end

  coax_sync_fifo #(
    .WIDTH (COAX_ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (fifoPush),
    .pushData (packEntry(pushLast, stagedWord)),
    .pop      (popReq),
    .popData  (fifoHead),
    .full     (fifoFull),
    .empty    (fifoEmpty)
  );

  assign outValid = !fifoEmpty;
  assign outLast  = fifoHead[COAX_ENTRY_W-1];
  assign outWord  = fifoHead[COAX_WORD_W-1:0];
  assign dbgState = state;

endmodule

// File: tb/tb_coax_rx_ctrl.sv
// tb_coax_rx_ctrl: directed bench for coax_rx_ctrl with default parameters.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled
// at the falling edge or at the drive point, never on the rising edge.
module tb_coax_rx_ctrl;
  import coax_pkg::*;

  localparam int DEPTH       = 16;
  localparam int EOF_TIMEOUT = 1024;
  localparam int TURNAROUND  = 256;

  // ---------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------
  logic        clk = 1'b0;
  logic        reset;
  logic        txBusy;
  logic        rxReset;
  logic [11:0] rxWord;
  logic        wordAvailable;
  logic [11:0] outWord;
  logic        outLast;
  logic        outValid;
  logic        outReady;
  logic        frameActive;
  logic        overflow;
  logic        overflowClear;
  coax_state_t dbgState;

  always #5 clk = ~clk;

  coax_rx_ctrl #(
    .DEPTH       (DEPTH),
    .EOF_TIMEOUT (EOF_TIMEOUT),
    .TURNAROUND  (TURNAROUND)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .txBusy        (txBusy),
    .rxReset       (rxReset),
    .rxWord        (rxWord),
    .wordAvailable (wordAvailable),
    .outWord       (outWord),
    .outLast       (outLast),
    .outValid      (outValid),
    .outReady      (outReady),
    .frameActive   (frameActive),
    .overflow      (overflow),
    .overflowClear (overflowClear),
    .dbgState      (dbgState)
  );

  // ---------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------
  logic [12:0] exp_q[$];
  logic [12:0] mon_exp;
  int          n_compared   = 0;
  int          n_mismatched = 0;
  int          last_seen    = 0;
  int          edges;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [12:0] ent(input logic last, input int w);
    logic [31:0] wv;
    wv = w;
    return {last, wv[11:0]};
  endfunction

  // Every accepted host transfer is checked against the expected queue.
  always @(negedge clk) begin
    if (reset && outValid && outReady) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_out", {19'd0, outLast, outWord}, 32'h0);
      end else begin
        mon_exp = exp_q.pop_front();
        check_eq("out_entry", {19'd0, outLast, outWord}, {19'd0, mon_exp});
      end
      if (outLast) last_seen++;
    end
  end

  // ---------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------
  task automatic next_drive(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic strobe(input int w);
    logic [31:0] wv;
    wv = w;
    rxWord        = wv[11:0];
    wordAvailable = 1'b1;
    next_drive(1);
    wordAvailable = 1'b0;
  endtask

  // Edges from the current drive point until rxReset is seen low.
  task automatic count_to_release(output int n);
    n = 0;
    for (int i = 0; i < TURNAROUND + 50; i++) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (!rxReset) return;
    end
    n = -1;
  endtask

  // Strobe the closing word of a frame and count edges until its last=1
  // entry is visible at the head of the FIFO.
  task automatic measure_close(input int w, output int n);
    strobe(w);
    n = 1;
    for (int i = 0; i < EOF_TIMEOUT + 50; i++) begin
      @(negedge clk);
      if (outValid && outLast) return;
      @(posedge clk);
      n++;
    end
    n = -1;
  endtask

  task automatic go_idle();
    txBusy = 1'b0;
    next_drive(TURNAROUND + 4);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------
  // Directed stimulus
  // ---------------------------------------------------------------------
  initial begin
    reset         = 1'b0;
    txBusy        = 1'b0;
    rxWord        = '0;
    wordAvailable = 1'b0;
    outReady      = 1'b0;
    overflowClear = 1'b0;

    // Reset values
    next_drive(3);
    @(negedge clk);
    check_eq("rst_rxReset",     rxReset,     1);
    check_eq("rst_outValid",    outValid,    0);
    check_eq("rst_outWord",     outWord,     0);
    check_eq("rst_outLast",     outLast,     0);
    check_eq("rst_frameActive", frameActive, 0);
    check_eq("rst_overflow",    overflow,    0);
    check_eq("rst_state",       dbgState,    HOLD);

    // Turnaround after reset release: one edge HOLD->TURN, TURNAROUND edges
    // in TURN, then one more edge for the registered rxReset.
    next_drive(1);
    reset = 1'b1;
    count_to_release(edges);
    check_eq("turn_len_reset", edges, TURNAROUND + 2);
    check_eq("turn_idle_state", dbgState, IDLE);

    // txBusy rise in IDLE: rxReset follows two edges later
    next_drive(1);
    txBusy = 1'b1;
    settle();
    check_eq("busy_idle_state", dbgState, HOLD);
    check_eq("busy_idle_rx_1", rxReset, 0);
    settle();
    check_eq("busy_idle_rx_2", rxReset, 1);

    // txBusy during TURN aborts and the count restarts on the next fall
    next_drive(1);
    txBusy = 1'b0;
    next_drive(100);
    check_eq("turn_mid_state", dbgState, TURN);
    txBusy = 1'b1;
    settle();
    check_eq("turn_abort_state", dbgState, HOLD);
    check_eq("turn_abort_rx", rxReset, 1);
    next_drive(1);
    txBusy = 1'b0;
    count_to_release(edges);
    check_eq("turn_len_restart", edges, TURNAROUND + 2);

    // Single frame, 500-clock spacing, host always ready
    next_drive(1);
    outReady = 1'b1;
    exp_q.push_back(ent(1'b0, 'h5A1));
    exp_q.push_back(ent(1'b0, 'h123));
    exp_q.push_back(ent(1'b1, 'hFFF));
    strobe('h5A1);
    settle();
    check_eq("frame_active_on", frameActive, 1);
    next_drive(497);
    strobe('h123);
    next_drive(499);
    measure_close('hFFF, edges);
    check_eq("eof_latency", edges, EOF_TIMEOUT + 1);
    settle();
    settle();
    check_eq("frame_active_off", frameActive, 0);
    check_eq("single_drained", exp_q.size(), 0);

    // Back-to-back frames separated by 2000 idle clocks
    next_drive(1);
    last_seen = 0;
    exp_q.push_back(ent(1'b0, 'h001));
    exp_q.push_back(ent(1'b1, 'h002));
    exp_q.push_back(ent(1'b1, 'h003));
    strobe('h001);
    next_drive(10);
    strobe('h002);
    next_drive(1500);
    check_eq("gap_frame_inactive", frameActive, 0);
    next_drive(500);
    strobe('h003);
    next_drive(EOF_TIMEOUT + 20);
    check_eq("b2b_last_count", last_seen, 2);
    check_eq("b2b_drained", exp_q.size(), 0);

    // Overflow: 20 words into a 16-entry FIFO with the host stalled
    outReady = 1'b0;
    for (int k = 0; k < 20; k++) begin
      strobe('h100 + k);
      next_drive(1);
    end
    check_eq("ovf_set", overflow, 1);
    check_eq("ovf_head", {19'd0, outLast, outWord}, {19'd0, ent(1'b0, 'h100)});
    next_drive(EOF_TIMEOUT + 20);
    overflowClear = 1'b1;
    next_drive(1);
    overflowClear = 1'b0;
    check_eq("ovf_cleared", overflow, 0);
    strobe('h2AA);
    next_drive(1);
    overflowClear = 1'b1;
    strobe('h2BB);
    overflowClear = 1'b0;
    check_eq("ovf_set_beats_clear", overflow, 1);
    next_drive(EOF_TIMEOUT + 20);
    for (int k = 0; k < 16; k++) exp_q.push_back(ent(1'b0, 'h100 + k));
    outReady = 1'b1;
    next_drive(40);
    check_eq("ovf_drained", exp_q.size(), 0);
    check_eq("ovf_empty", outValid, 0);

    // Push and pop in the same cycle on a full FIFO: no drop
    overflowClear = 1'b1;
    next_drive(1);
    overflowClear = 1'b0;
    outReady = 1'b0;
    for (int k = 0; k < 17; k++) begin
      strobe('h300 + k);
      next_drive(1);
    end
    check_eq("full_no_ovf_yet", overflow, 0);
    for (int k = 0; k < 17; k++) exp_q.push_back(ent(1'b0, 'h300 + k));
    exp_q.push_back(ent(1'b1, 'h311));
    outReady = 1'b1;
    strobe('h311);
    check_eq("full_pushpop_no_ovf", overflow, 0);
    next_drive(EOF_TIMEOUT + 40);
    check_eq("full_pushpop_drained", exp_q.size(), 0);

    // txBusy mid-frame together with a third strobe
    exp_q.push_back(ent(1'b0, 'h0A0));
    exp_q.push_back(ent(1'b1, 'h0B0));
    strobe('h0A0);
    next_drive(5);
    strobe('h0B0);
    next_drive(5);
    rxWord        = 12'h0C0;
    wordAvailable = 1'b1;
    txBusy        = 1'b1;
    next_drive(1);
    wordAvailable = 1'b0;
    check_eq("busy_frame_state", dbgState, HOLD);
    next_drive(2);
    check_eq("busy_frame_rx", rxReset, 1);
    next_drive(5);
    check_eq("busy_frame_drained", exp_q.size(), 0);
    check_eq("busy_frame_empty", outValid, 0);
    go_idle();

    // Reset mid-frame with 5 words buffered and one staged
    outReady = 1'b0;
    for (int k = 0; k < 6; k++) begin
      strobe('h400 + k);
      next_drive(1);
    end
    check_eq("pre_reset_valid", outValid, 1);
    reset = 1'b0;
    next_drive(1);
    check_eq("midrst_outValid", outValid, 0);
    check_eq("midrst_outWord", outWord, 0);
    check_eq("midrst_rxReset", rxReset, 1);
    check_eq("midrst_frameActive", frameActive, 0);
    reset    = 1'b1;
    outReady = 1'b1;
    next_drive(TURNAROUND + EOF_TIMEOUT + 100);
    check_eq("post_rst_empty", outValid, 0);
    check_eq("post_rst_idle", dbgState, IDLE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
